// File: rtl/opb_register_ppc2simulink_bank.sv
// OPB slave bank of PPC-written control registers: byte-masked shadow copies are committed
// atomically to the user-facing active copies, with a one-cycle strobe and a wrapping commit count.

module opb_p2s_lane #(
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  input  logic        commit,
  output logic [31:0] shadow,
  output logic [31:0] active
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= RESET_VALUE;
      active <= RESET_VALUE;
    end else begin
      if (wr)
        for (int b = 0; b < 4; b++)
          if (be[b]) shadow[8*b +: 8] <= wdata[8*b +: 8];
      if (commit) active <= shadow;
    end
  end
endmodule

module opb_register_ppc2simulink_bank #(
  parameter logic [31:0] C_BASEADDR    = 32'h01020300,
  parameter logic [31:0] C_HIGHADDR    = 32'h010203FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 4,
  parameter logic [31:0] C_RESET_VALUE = 32'h00000000
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic                    Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0] user_data_out,
  output logic                    user_commit
);
  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t                           state;
  logic [C_OPB_AWIDTH-1:0]          addr;
  logic [C_OPB_DWIDTH-1:0]          wdata;
  logic [31:0]                      off, rd_data, dbus_q;
  logic [5:0]                       widx;
  logic [3:0]                       be;
  logic                             in_win, start, ctrl_hit, commit_req, do_commit, pending;
  logic [15:0]                      commit_cnt;
  logic [C_NUM_REGS-1:0]            sh_wr;
  logic [C_NUM_REGS-1:0][31:0]      shadow_q, active_q;

  // Big-endian OPB vectors map MSB-to-MSB, so numeric values carry over unchanged.
  assign addr     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign be       = OPB_BE;
  assign in_win   = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign off      = addr - C_BASEADDR;
  assign widx     = off[7:2];
  assign start    = (state == S_IDLE) && OPB_select && in_win;
  assign ctrl_hit = (widx == 6'h10);
  assign do_commit = (state == S_ACK) && commit_req;

  always_comb begin
    rd_data = '0;
    sh_wr   = '0;
    if (ctrl_hit) rd_data = {commit_cnt, 15'b0, pending};
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (widx == 6'(i)) begin
        rd_data  = shadow_q[i];
        sh_wr[i] = start && !OPB_RNW;
      end
      if (widx == 6'(32 + i)) rd_data = active_q[i];
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_lane
    opb_p2s_lane #(.RESET_VALUE(C_RESET_VALUE)) u_lane (
      .clk    (OPB_Clk),
      .rst    (OPB_Rst),
      .wr     (sh_wr[g]),
      .be     (be),
      .wdata  (wdata),
      .commit (do_commit),
      .shadow (shadow_q[g]),
      .active (active_q[g])
    );
  end

  // Writes land on the edge entering ACK; the commit copy happens one edge later,
  // so a shadow write can never race the copy.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state       <= S_IDLE;
      Sl_xferAck  <= 1'b0;
      dbus_q      <= '0;
      user_commit <= 1'b0;
      commit_req  <= 1'b0;
      commit_cnt  <= '0;
      pending     <= 1'b0;
    end else begin
      user_commit <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state      <= S_ACK;
          Sl_xferAck <= 1'b1;
          dbus_q     <= OPB_RNW ? rd_data : 32'h0;
          commit_req <= !OPB_RNW && ctrl_hit && be[0] && wdata[0];
          if (|sh_wr) pending <= 1'b1;
        end
        S_ACK: begin
          state      <= S_WAIT;
          Sl_xferAck <= 1'b0;
          dbus_q     <= '0;
          commit_req <= 1'b0;
          if (commit_req) begin
            user_commit <= 1'b1;
            commit_cnt  <= commit_cnt + 16'd1;
            pending     <= 1'b0;
          end
        end
        default: if (!OPB_select) state <= S_IDLE;
      endcase
    end
  end

  assign Sl_DBus       = dbus_q;
  assign Sl_errAck     = 1'b0;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;
  assign user_data_out = active_q;

  wire unused_ok = &{1'b0, OPB_seqAddr, off[31:8], off[1:0]};
endmodule

// File: tb/tb_opb_register_ppc2simulink_bank.sv
// Directed bench: stimulus queues expected read data / commit contents, monitors pop and compare.

module tb_opb_register_ppc2simulink_bank;
  localparam logic [31:0] BASE = 32'h01020300;

  logic         OPB_Clk = 0, OPB_Rst = 1;
  logic [0:31]  OPB_ABus = '0, OPB_DBus = '0;
  logic [0:3]   OPB_BE = '0;
  logic         OPB_RNW = 0, OPB_select = 0, OPB_seqAddr = 0;
  logic [0:31]  Sl_DBus;
  logic         Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck, user_commit;
  logic [127:0] user_data_out;

  int n_cmp = 0, n_bad = 0;
  logic [31:0]  exp_q[$];
  logic [127:0] com_q[$];

  opb_register_ppc2simulink_bank dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .Sl_xferAck(Sl_xferAck), .user_data_out(user_data_out), .user_commit(user_commit)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus monitor: every ack consumes one expected data word; idle bus must read 0.
  always @(negedge OPB_Clk) begin
    if (Sl_xferAck) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 1, 0);
      else chk("ack_data", Sl_DBus, exp_q.pop_front());
    end else if (!OPB_Rst) begin
      chk("idle_dbus", Sl_DBus, 0);
    end
  end

  // Commit monitor: each strobe cycle must match a queued active-register image.
  always @(negedge OPB_Clk) begin
    if (user_commit) begin
      if (com_q.size() == 0) chk("unexpected_commit", 1, 0);
      else chk("commit_data", user_data_out, com_q.pop_front());
    end
  end

  // Called at posedge+1 with FSM idle; returns at posedge+1 with FSM idle again.
  task automatic xfer(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input logic rnw, input logic [31:0] exp);
    int n = 0;
    logic got = 0;
    exp_q.push_back(exp);
    OPB_ABus = a; OPB_BE = be; OPB_DBus = d; OPB_RNW = rnw; OPB_select = 1;
    while (!got && n < 8) begin
      @(negedge OPB_Clk); n++;
      if (Sl_xferAck) got = 1;
    end
    chk("ack_latency", n, 2);
    @(posedge OPB_Clk); #1 OPB_select = 0;
    @(posedge OPB_Clk); #1;
  endtask

  task automatic wr(input logic [31:0] o, input logic [3:0] be, input logic [31:0] d);
    xfer(BASE + o, be, d, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] o, input logic [31:0] exp);
    xfer(BASE + o, 4'b1111, 32'h0, 1'b1, exp);
  endtask

  task automatic hold(input logic [31:0] a, input int cycles, input int exp_acks, input string name);
    int acks = 0;
    OPB_ABus = a; OPB_BE = 4'b1111; OPB_RNW = 1; OPB_select = 1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck) acks++;
    end
    chk(name, acks, exp_acks);
    @(posedge OPB_Clk); #1 OPB_select = 0;
    @(posedge OPB_Clk); #1;
  endtask

  task automatic commit(input logic [127:0] img);
    com_q.push_back(img);
    wr(32'h40, 4'b0001, 32'h00000001);
  endtask

  initial begin
    logic [127:0] img;
    repeat (3) @(posedge OPB_Clk);
    #1;
    chk("rst_ack", Sl_xferAck, 0);
    chk("rst_dbus", Sl_DBus, 0);
    chk("rst_user", user_data_out, 0);
    chk("rst_commit", user_commit, 0);
    chk("tied_outs", {Sl_errAck, Sl_retry, Sl_toutSup}, 0);
    OPB_Rst = 0;
    @(posedge OPB_Clk); #1;

    wr(32'h00, 4'b1111, 32'hDEADBEEF);
    chk("user_before_commit", user_data_out[31:0], 0);
    rd(32'h40, 32'h00000001);
    rd(32'h00, 32'hDEADBEEF);

    img = {96'h0, 32'hDEADBEEF};
    commit(img);
    chk("user_after_commit", user_data_out, img);
    rd(32'h40, 32'h00010000);

    wr(32'h04, 4'b1111, 32'h11223344);
    wr(32'h04, 4'b0100, 32'hAABBCCDD);
    rd(32'h04, 32'h11BB3344);
    rd(32'h40, 32'h00010001);

    exp_q.push_back(32'hDEADBEEF);
    hold(BASE + 32'h80, 5, 1, "held_select_acks");

    rd(32'h3C, 32'h0);
    hold(32'h00000200, 4, 0, "out_of_window_acks");
    wr(32'h80, 4'b1111, 32'h12345678);
    rd(32'h80, 32'hDEADBEEF);
    rd(32'h84, 32'h0);
    chk("active_write_dropped", user_data_out, img);

    img = {64'h0, 32'h11BB3344, 32'hDEADBEEF};
    commit(img);
    rd(32'h40, 32'h00020000);
    commit(img);
    rd(32'h40, 32'h00030000);

    @(negedge OPB_Clk);
    force dut.commit_cnt = 16'hFFFE;
    @(negedge OPB_Clk);
    release dut.commit_cnt;
    @(posedge OPB_Clk); #1;
    commit(img);
    rd(32'h40, 32'hFFFF0000);
    commit(img);
    rd(32'h40, 32'h00000000);

    // Reset lands mid-ACK: the ack must vanish without waiting for a clock edge.
    exp_q.push_back(32'h0);
    OPB_ABus = BASE + 32'h08; OPB_BE = 4'b1111; OPB_DBus = 32'hCAFEF00D;
    OPB_RNW = 0; OPB_select = 1;
    @(negedge OPB_Clk);
    @(negedge OPB_Clk);
    chk("ack_before_reset", Sl_xferAck, 1);
    #2 OPB_Rst = 1;
    #1;
    chk("ack_async_drop", Sl_xferAck, 0);
    chk("user_async_reset", user_data_out, 0);
    @(posedge OPB_Clk); #1 OPB_select = 0;
    @(posedge OPB_Clk); #1 OPB_Rst = 0;
    @(posedge OPB_Clk); #1;
    rd(32'h00, 32'h0);
    rd(32'h08, 32'h0);
    rd(32'h40, 32'h0);

    repeat (3) @(posedge OPB_Clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("com_q_drained", com_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
